// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU control decoder with multi-cycle MUL/DIV sequencing.
// Optional M extension decode and EXEC sequencing enabled by `define ALU_CTRL_MEXT_EN.
`timescale 1ns/1ps
module alu_ctrl_seq #(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] alu_ctrl,
  output logic       illegal,
  output logic       busy
);

  localparam int unsigned CODE_W = 5;

  localparam logic [CODE_W-1:0] OP_AND  = 5'b00000;
  localparam logic [CODE_W-1:0] OP_OR   = 5'b00001;
  localparam logic [CODE_W-1:0] OP_ADD  = 5'b00010;
  localparam logic [CODE_W-1:0] OP_XOR  = 5'b00011;
  localparam logic [CODE_W-1:0] OP_SLL  = 5'b00100;
  localparam logic [CODE_W-1:0] OP_SRL  = 5'b00101;
  localparam logic [CODE_W-1:0] OP_SUB  = 5'b00110;
  localparam logic [CODE_W-1:0] OP_SRA  = 5'b00111;
  localparam logic [CODE_W-1:0] OP_SLT  = 5'b01000;
  localparam logic [CODE_W-1:0] OP_SLTU = 5'b01001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
`ifdef ALU_CTRL_MEXT_EN
  localparam logic [6:0] F7_MEXT = 7'b0000001;
`endif

  localparam logic [1:0] ST_IDLE  = 2'd0;
`ifdef ALU_CTRL_MEXT_EN
  localparam logic [1:0] ST_EXEC  = 2'd1;
`endif
  localparam logic [1:0] ST_VALID = 2'd2;

  if (MUL_LAT < 1 || DIV_LAT < 1) begin : g_lat_check
    $error("alu_ctrl_seq: MUL_LAT and DIV_LAT must be at least 1");
  end

`ifdef ALU_CTRL_MEXT_EN
  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic [1:0]        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              ill_q, ill_d;
  logic [CODE_W-1:0] dec_code;
  logic              dec_ill;
  logic              accept;

  // Pure decode of the presented encoding; illegal encodings leave the code at 00000.
  always_comb begin
    dec_code = OP_AND;
    dec_ill  = 1'b0;
    case (aluop)
      2'b00: dec_code = OP_ADD;
      2'b01: begin
        case (funct3)
          3'b000, 3'b001: dec_code = OP_SUB;
          3'b100, 3'b101: dec_code = OP_SLT;
          3'b110, 3'b111: dec_code = OP_SLTU;
          default:        dec_ill  = 1'b1;
        endcase
      end
      2'b10: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  dec_code = OP_ADD;
            3'b001:  dec_code = OP_SLL;
            3'b010:  dec_code = OP_SLT;
            3'b011:  dec_code = OP_SLTU;
            3'b100:  dec_code = OP_XOR;
            3'b101:  dec_code = OP_SRL;
            3'b110:  dec_code = OP_OR;
            default: dec_code = OP_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            3'b000:  dec_code = OP_SUB;
            3'b101:  dec_code = OP_SRA;
            default: dec_ill  = 1'b1;
          endcase
`ifdef ALU_CTRL_MEXT_EN
        end else if (funct7 == F7_MEXT) begin
          // M codes are 10 followed by funct3.
          dec_code = {2'b10, funct3};
`endif
        end else begin
          dec_ill = 1'b1;
        end
      end
      default: begin
        case (funct3)
          3'b000: dec_code = OP_ADD;
          3'b010: dec_code = OP_SLT;
          3'b011: dec_code = OP_SLTU;
          3'b100: dec_code = OP_XOR;
          3'b110: dec_code = OP_OR;
          3'b111: dec_code = OP_AND;
          3'b001: begin
            if (funct7 == F7_BASE) dec_code = OP_SLL;
            else                   dec_ill  = 1'b1;
          end
          default: begin
            if (funct7 == F7_BASE)     dec_code = OP_SRL;
            else if (funct7 == F7_ALT) dec_code = OP_SRA;
            else                       dec_ill  = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_VALID) & out_ready);
  assign accept   = in_valid & in_ready;

  // Next-state and next-output-word logic.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    ill_d   = ill_q;
`ifdef ALU_CTRL_MEXT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_VALID: begin
        if (out_ready) state_d = ST_IDLE;
      end
`ifdef ALU_CTRL_MEXT_EN
      ST_EXEC: begin
        if (cnt_q == '0) state_d = ST_VALID;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // A new op can only be accepted from IDLE or a consumed VALID.
    if (accept) begin
      code_d  = dec_code;
      ill_d   = dec_ill;
      state_d = ST_VALID;
`ifdef ALU_CTRL_MEXT_EN
      if (dec_code[4]) begin
        state_d = ST_EXEC;
        cnt_d   = dec_code[2] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      ill_q   <= 1'b0;
`ifdef ALU_CTRL_MEXT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      ill_q   <= ill_d;
`ifdef ALU_CTRL_MEXT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign out_valid = (state_q == ST_VALID);
  assign alu_ctrl  = code_q;
  assign illegal   = ill_q;
`ifdef ALU_CTRL_MEXT_EN
  assign busy      = (state_q == ST_EXEC);
`else
  assign busy      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed + sweep bench for alu_ctrl_seq with a queue scoreboard on the output handshake.
`timescale 1ns/1ps
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] aluop = 2'b00;
  logic [2:0] funct3 = 3'b000;
  logic [6:0] funct7 = 7'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [4:0] alu_ctrl;
  logic       illegal;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [5:0] sb[$];

  localparam logic [5:0] E_ILL  = 6'b1_00000;
  localparam logic [5:0] E_AND  = 6'b0_00000;
  localparam logic [5:0] E_OR   = 6'b0_00001;
  localparam logic [5:0] E_ADD  = 6'b0_00010;
  localparam logic [5:0] E_XOR  = 6'b0_00011;
  localparam logic [5:0] E_SLL  = 6'b0_00100;
  localparam logic [5:0] E_SRL  = 6'b0_00101;
  localparam logic [5:0] E_SUB  = 6'b0_00110;
  localparam logic [5:0] E_SRA  = 6'b0_00111;
  localparam logic [5:0] E_SLT  = 6'b0_01000;
  localparam logic [5:0] E_SLTU = 6'b0_01001;

  always #5 clk = ~clk;

  alu_ctrl_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .funct3    (funct3),
    .funct7    (funct7),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_ctrl  (alu_ctrl),
    .illegal   (illegal),
    .busy      (busy)
  );

  // Reference decode: {illegal, alu_ctrl}.
  function automatic logic [5:0] model(input logic [1:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7);
    case (op)
      2'b00: return E_ADD;
      2'b01: begin
        if (f3 == 3'd0 || f3 == 3'd1) return E_SUB;
        if (f3 == 3'd4 || f3 == 3'd5) return E_SLT;
        if (f3 == 3'd6 || f3 == 3'd7) return E_SLTU;
        return E_ILL;
      end
      2'b10: begin
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: return E_ADD;
            3'd1: return E_SLL;
            3'd2: return E_SLT;
            3'd3: return E_SLTU;
            3'd4: return E_XOR;
            3'd5: return E_SRL;
            3'd6: return E_OR;
            default: return E_AND;
          endcase
        end
        if (f7 == 7'h20) begin
          if (f3 == 3'd0) return E_SUB;
          if (f3 == 3'd5) return E_SRA;
          return E_ILL;
        end
`ifdef ALU_CTRL_MEXT_EN
        if (f7 == 7'h01) return {3'b010, f3};
`endif
        return E_ILL;
      end
      default: begin
        case (f3)
          3'd0: return E_ADD;
          3'd2: return E_SLT;
          3'd3: return E_SLTU;
          3'd4: return E_XOR;
          3'd6: return E_OR;
          3'd7: return E_AND;
          3'd1: return (f7 == 7'h00) ? E_SLL : E_ILL;
          default: return (f7 == 7'h00) ? E_SRL : ((f7 == 7'h20) ? E_SRA : E_ILL);
        endcase
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Present an op (called just after a rising edge); returns once it has been accepted.
  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      output int waited);
    bit got;
    got    = 1'b0;
    waited = 0;
    aluop  = op;
    funct3 = f3;
    funct7 = f7;
    in_valid = 1'b1;
    while (!got && waited < 200) begin
      sample();
      if (in_ready) begin
        got = 1'b1;
        sb.push_back(model(op, f3, f7));
      end else begin
        waited++;
      end
      step();
    end
    chk("accept_timeout", 32'(got), 32'd1);
  endtask

  // Scoreboard: every consumed output must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [5:0] exp_v;
    if (!rst && out_valid && out_ready) begin
      exp_v = (sb.size() > 0) ? sb.pop_front() : 6'bxxxxxx;
      checks++;
      assert ({illegal, alu_ctrl} === exp_v) else begin
        errors++;
        $error("FAIL sb_out observed=%0h expected=%0h", {illegal, alu_ctrl}, exp_v);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    logic [6:0] f7s[5];

    // Reset values.
    rst = 1'b1;
    repeat (3) step();
    sample();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    step();

    // SUB, one-cycle latency, then drain to IDLE.
    send(2'b10, 3'b000, 7'h20, w);
    in_valid = 1'b0;
    sample();
    chk("sub_valid", 32'(out_valid), 32'd1);
    chk("sub_code", 32'(alu_ctrl), 32'h06);
    chk("sub_illegal", 32'(illegal), 32'd0);
    step();
    sample();
    chk("sub_drained", 32'(out_valid), 32'd0);
    step();

    // Back-to-back SRA then SLTU.
    send(2'b11, 3'b101, 7'h20, w);
    chk("b2b_first_wait", 32'(w), 32'd0);
    send(2'b01, 3'b110, 7'h00, w);
    chk("b2b_second_wait", 32'(w), 32'd0);
    in_valid = 1'b0;
    sample();
    chk("b2b_sltu_code", 32'(alu_ctrl), 32'h09);
    chk("b2b_sltu_valid", 32'(out_valid), 32'd1);
    step();

    // Stall in VALID holding ADD while a new op is offered and must be ignored.
    out_ready = 1'b0;
    send(2'b00, 3'b011, 7'h7f, w);
    aluop = 2'b11; funct3 = 3'b100; funct7 = 7'h00;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_code", 32'(alu_ctrl), 32'h02);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    send(2'b11, 3'b100, 7'h00, w);
    chk("stall_release_wait", 32'(w), 32'd0);
    in_valid = 1'b0;
    sample();
    chk("stall_xor_code", 32'(alu_ctrl), 32'h03);
    step();

    // Illegal encodings: 1-cycle latency, code 00000.
    send(2'b01, 3'b010, 7'h00, w);
    in_valid = 1'b0;
    sample();
    chk("ill_br_valid", 32'(out_valid), 32'd1);
    chk("ill_br_flag", 32'(illegal), 32'd1);
    chk("ill_br_code", 32'(alu_ctrl), 32'd0);
    step();
    send(2'b11, 3'b001, 7'h20, w);
    in_valid = 1'b0;
    sample();
    chk("ill_sll_valid", 32'(out_valid), 32'd1);
    chk("ill_sll_flag", 32'(illegal), 32'd1);
    chk("ill_sll_code", 32'(alu_ctrl), 32'd0);
    step();

`ifdef ALU_CTRL_MEXT_EN
    // DIV: busy for 32 cycles, then VALID.
    send(2'b10, 3'b100, 7'h01, w);
    in_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      sample();
      chk("div_busy", 32'(busy), 32'd1);
      chk("div_in_ready", 32'(in_ready), 32'd0);
      chk("div_out_valid", 32'(out_valid), 32'd0);
      step();
    end
    sample();
    chk("div_done_valid", 32'(out_valid), 32'd1);
    chk("div_done_code", 32'(alu_ctrl), 32'h14);
    chk("div_done_busy", 32'(busy), 32'd0);
    step();

    // MULH: busy for 3 cycles.
    send(2'b10, 3'b001, 7'h01, w);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("mul_busy", 32'(busy), 32'd1);
      step();
    end
    sample();
    chk("mul_done_valid", 32'(out_valid), 32'd1);
    chk("mul_done_code", 32'(alu_ctrl), 32'h11);
    step();

    // Reset on EXEC cycle 10 of a REM.
    send(2'b10, 3'b110, 7'h01, w);
    in_valid = 1'b0;
    repeat (9) step();
    sample();
    chk("rst_exec_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    sample();
    chk("rst_exec_busy", 32'(busy), 32'd0);
    chk("rst_exec_valid", 32'(out_valid), 32'd0);
    chk("rst_exec_code", 32'(alu_ctrl), 32'd0);
    rst = 1'b0;
    sb.delete();
    step();
`else
    // Without the M extension the DIV encoding is illegal and single-cycle.
    send(2'b10, 3'b100, 7'h01, w);
    in_valid = 1'b0;
    sample();
    chk("nodiv_valid", 32'(out_valid), 32'd1);
    chk("nodiv_illegal", 32'(illegal), 32'd1);
    chk("nodiv_code", 32'(alu_ctrl), 32'd0);
    chk("nodiv_busy", 32'(busy), 32'd0);
    step();

    // Reset while holding a stalled result discards it.
    out_ready = 1'b0;
    send(2'b11, 3'b110, 7'h00, w);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    sample();
    chk("rst_hold_valid", 32'(out_valid), 32'd0);
    chk("rst_hold_code", 32'(alu_ctrl), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    sb.delete();
    step();
`endif

    // Sweep every aluop/funct3 against representative funct7 values.
    f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01; f7s[3] = 7'h7f;
    for (int op = 0; op < 4; op++) begin
      for (int f3 = 0; f3 < 8; f3++) begin
        f7s[4] = 7'($urandom);
        for (int k = 0; k < 5; k++) begin
          send(2'(op), 3'(f3), f7s[k], w);
        end
      end
    end
    in_valid = 1'b0;
    repeat (40) step();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
